uart_ctrl: RTL and testbench

- Controller sitting between SoC-side agents and the single `uart` instance.
- Shares the UART transmitter among N_REQ requesters with round-robin arbitration.
- Drains received bytes and errors from the UART through its `recv_ack` handshake.
- Owns the baud divisor register and applies updates only when the line is quiescent.

---
 rtl/uart_ctrl_pkg.sv | 15 +
 rtl/uart_ctrl_rr_arb.sv | 31 +++
 rtl/uart_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_uart_ctrl.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_ctrl_pkg.sv
// Shared types and constants for the UART controller.
package uart_ctrl_pkg;

    typedef enum logic [1:0] {
        TX_IDLE       = 2'd0,
        TX_ISSUE      = 2'd1,
        TX_WAIT_START = 2'd2,
        TX_WAIT_DONE  = 2'd3
    } tx_state_t;

    localparam int RX_FIFO_DEPTH = 4;
    localparam int RX_PTR_W      = $clog2(RX_FIFO_DEPTH);
    localparam int ERR_CNT_W     = 8;

endpackage

// File: rtl/uart_ctrl_rr_arb.sv
// Combinational round-robin picker: first valid requester after i_ptr, wrapping.
module uart_ctrl_rr_arb #(
    parameter int N_REQ = 4,
    parameter int PTR_W = 2
) (
    input  logic [N_REQ-1:0] i_valid,
    input  logic [PTR_W-1:0] i_ptr,
    output logic             o_any,
    output logic [PTR_W-1:0] o_winner,
    output logic [N_REQ-1:0] o_grant
);

    int w_idx;

    // Walk from farthest to nearest so the nearest valid index is written last.
    always_comb begin
        o_any    = 1'b0;
        o_winner = '0;
        o_grant  = '0;
        w_idx    = 0;
        for (int k = N_REQ; k >= 1; k--) begin
            w_idx = (int'(i_ptr) + k) % N_REQ;
            if (i_valid[w_idx]) begin
                o_any    = 1'b1;
                o_winner = PTR_W'(w_idx);
            end
        end
        o_grant[o_winner] = o_any;
    end

endmodule

// File: rtl/uart_ctrl.sv
// UART controller: round-robin TX sharing, RX drain with ack handshake, deferred baud updates.
// Define UART_CTRL_RX_FIFO_EN to replace the single RX holding register with a small FIFO.
module uart_ctrl
    import uart_ctrl_pkg::*;
#(
    parameter int          N_REQ        = 4,
    parameter logic [15:0] DEFAULT_BAUD = 16'd1302
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [8*N_REQ-1:0]   req_data,
    output logic [N_REQ-1:0]     req_ready,
    output logic                 rx_valid,
    output logic [7:0]           rx_data,
    input  logic                 rx_ready,
    output logic                 rx_overrun,
    output logic [ERR_CNT_W-1:0] rx_err_cnt,
    input  logic                 stat_clr,
    input  logic                 cfg_baud_we,
    input  logic [15:0]          cfg_baud_wdata,
    output logic                 uart_transmit,
    output logic [7:0]           uart_tx_byte,
    input  logic                 uart_is_transmitting,
    input  logic                 uart_is_receiving,
    input  logic                 uart_received,
    input  logic [7:0]           uart_rx_byte,
    input  logic                 uart_recv_error,
    output logic                 uart_recv_ack,
    output logic [15:0]          uart_baud
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    tx_state_t            r_state;
    logic [PTR_W-1:0]     r_ptr;
    logic [7:0]           r_tx_byte;
    logic                 r_transmit;
    logic [15:0]          r_baud;
    logic [15:0]          r_baud_pend;
    logic                 r_baud_pend_vld;
    logic                 r_ack;
    logic                 r_overrun;
    logic [ERR_CNT_W-1:0] r_err_cnt;

    logic                 w_any;
    logic [PTR_W-1:0]     w_winner;
    logic [N_REQ-1:0]     w_onehot;
    logic                 w_apply;
    logic                 w_grant;
    logic                 w_cap;
    logic                 w_err;
    logic                 w_pop;
    logic                 w_drop;

    uart_ctrl_rr_arb #(.N_REQ(N_REQ), .PTR_W(PTR_W)) u_arb (
        .i_valid  (req_valid),
        .i_ptr    (r_ptr),
        .o_any    (w_any),
        .o_winner (w_winner),
        .o_grant  (w_onehot)
    );

    // A baud apply steals the IDLE cycle so the divisor never changes under a fresh grant.
    assign w_apply   = r_baud_pend_vld && (r_state == TX_IDLE)
                       && !uart_is_transmitting && !uart_is_receiving;
    assign w_grant   = (r_state == TX_IDLE) && w_any && !uart_is_transmitting && !w_apply;
    assign req_ready = w_grant ? w_onehot : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= TX_IDLE;
            r_ptr      <= '0;
            r_tx_byte  <= '0;
            r_transmit <= 1'b0;
        end else begin
            r_transmit <= 1'b0;
            case (r_state)
                TX_IDLE: begin
                    if (w_grant) begin
                        r_tx_byte  <= req_data[int'(w_winner)*8 +: 8];
                        r_ptr      <= w_winner;
                        r_transmit <= 1'b1;
                        r_state    <= TX_ISSUE;
                    end
                end
                TX_ISSUE:      r_state <= TX_WAIT_START;
                TX_WAIT_START: if (uart_is_transmitting)  r_state <= TX_WAIT_DONE;
                TX_WAIT_DONE:  if (!uart_is_transmitting) r_state <= TX_IDLE;
                default:       r_state <= TX_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_baud          <= DEFAULT_BAUD;
            r_baud_pend     <= '0;
            r_baud_pend_vld <= 1'b0;
        end else begin
            if (w_apply) begin
                r_baud          <= r_baud_pend;
                r_baud_pend_vld <= 1'b0;
            end
            if (cfg_baud_we && (cfg_baud_wdata != '0)) begin
                r_baud_pend     <= cfg_baud_wdata;
                r_baud_pend_vld <= 1'b1;
            end
        end
    end

    // While ack is high the UART flags are stale; an error masks a simultaneous byte.
    assign w_cap = uart_received && !uart_recv_error && !r_ack;
    assign w_err = uart_recv_error && !r_ack;
    assign w_pop = rx_valid && rx_ready;

`ifdef UART_CTRL_RX_FIFO_EN
    logic [7:0]          r_fifo [RX_FIFO_DEPTH];
    logic [RX_PTR_W-1:0] r_wr;
    logic [RX_PTR_W-1:0] r_rd;
    logic [RX_PTR_W:0]   r_cnt;
    logic                w_push;

    assign w_push = w_cap && ((int'(r_cnt) != RX_FIFO_DEPTH) || w_pop);
    assign w_drop = w_cap && !w_push;

    always_ff @(posedge clk) begin
        if (w_push) r_fifo[r_wr] <= uart_rx_byte;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + RX_PTR_W'(1);
            if (w_pop)  r_rd <= r_rd + RX_PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + (RX_PTR_W+1)'(1);
                2'b01:   r_cnt <= r_cnt - (RX_PTR_W+1)'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    assign rx_valid = (r_cnt != '0);
    assign rx_data  = r_fifo[r_rd];
`else
    logic       r_rx_valid;
    logic [7:0] r_rx_data;

    assign w_drop = w_cap && r_rx_valid && !w_pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_valid <= 1'b0;
            r_rx_data  <= '0;
        end else if (w_cap && (!r_rx_valid || w_pop)) begin
            r_rx_valid <= 1'b1;
            r_rx_data  <= uart_rx_byte;
        end else if (w_pop) begin
            r_rx_valid <= 1'b0;
        end
    end

    assign rx_valid = r_rx_valid;
    assign rx_data  = r_rx_data;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ack     <= 1'b0;
            r_overrun <= 1'b0;
            r_err_cnt <= '0;
        end else begin
            r_ack <= w_cap || w_err;
            if (stat_clr)    r_overrun <= 1'b0;
            else if (w_drop) r_overrun <= 1'b1;
            if (stat_clr)                         r_err_cnt <= '0;
            else if (w_err && (r_err_cnt != '1))  r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
        end
    end

    assign uart_transmit = r_transmit;
    assign uart_tx_byte  = r_tx_byte;
    assign uart_baud     = r_baud;
    assign uart_recv_ack = r_ack;
    assign rx_overrun    = r_overrun;
    assign rx_err_cnt    = r_err_cnt;

endmodule

// File: tb/tb_uart_ctrl.sv
// Self-checking bench for uart_ctrl: baud vector table, hand sequences, and randomized TX/RX
// traffic scored against transaction-level reference models.
module tb_uart_ctrl;

    localparam int          N        = 4;
    localparam logic [15:0] DEF_BAUD = 16'd1302;
`ifdef UART_CTRL_RX_FIFO_EN
    localparam int RX_CAP = 4;
`else
    localparam int RX_CAP = 1;
`endif

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic           rx_valid;
    logic [7:0]     rx_data;
    logic           rx_ready;
    logic           rx_overrun;
    logic [7:0]     rx_err_cnt;
    logic           stat_clr;
    logic           cfg_baud_we;
    logic [15:0]    cfg_baud_wdata;
    logic           uart_transmit;
    logic [7:0]     uart_tx_byte;
    logic           uart_is_transmitting;
    logic           uart_is_receiving;
    logic           uart_received;
    logic [7:0]     uart_rx_byte;
    logic           uart_recv_error;
    logic           uart_recv_ack;
    logic [15:0]    uart_baud;

    logic man_tx = 1'b0;
    logic mdl_en = 1'b0;
    logic mdl_tx;
    int   mdl_dly;
    int   mdl_len;
    int   m_ptr;
    int   grants[$];
    int   n_pass = 0;
    int   n_tot  = 0;

    always #5 clk = ~clk;

    assign uart_is_transmitting = mdl_en ? mdl_tx : man_tx;

    uart_ctrl #(.N_REQ(N), .DEFAULT_BAUD(DEF_BAUD)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .req_valid            (req_valid),
        .req_data             (req_data),
        .req_ready            (req_ready),
        .rx_valid             (rx_valid),
        .rx_data              (rx_data),
        .rx_ready             (rx_ready),
        .rx_overrun           (rx_overrun),
        .rx_err_cnt           (rx_err_cnt),
        .stat_clr             (stat_clr),
        .cfg_baud_we          (cfg_baud_we),
        .cfg_baud_wdata       (cfg_baud_wdata),
        .uart_transmit        (uart_transmit),
        .uart_tx_byte         (uart_tx_byte),
        .uart_is_transmitting (uart_is_transmitting),
        .uart_is_receiving    (uart_is_receiving),
        .uart_received        (uart_received),
        .uart_rx_byte         (uart_rx_byte),
        .uart_recv_error      (uart_recv_error),
        .uart_recv_ack        (uart_recv_ack),
        .uart_baud            (uart_baud)
    );

    // Behavioural UART transmitter: busy starts 1..3 cycles after the strobe, lasts 2..6 cycles.
    always @(posedge clk) begin
        if (!mdl_en) begin
            mdl_tx  <= 1'b0;
            mdl_dly <= 0;
            mdl_len <= 0;
        end else if (uart_transmit) begin
            mdl_dly <= int'($urandom_range(1, 3));
            mdl_len <= int'($urandom_range(2, 6));
        end else if (mdl_dly > 0) begin
            if (mdl_dly == 1) mdl_tx <= 1'b1;
            mdl_dly <= mdl_dly - 1;
        end else if (mdl_tx) begin
            if (mdl_len == 1) mdl_tx <= 1'b0;
            mdl_len <= mdl_len - 1;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        req_valid = '0; req_data = '0; rx_ready = 1'b0; stat_clr = 1'b0;
        cfg_baud_we = 1'b0; cfg_baud_wdata = '0; man_tx = 1'b0;
        uart_is_receiving = 1'b0; uart_received = 1'b0; uart_rx_byte = '0;
        uart_recv_error = 1'b0;
    endtask

    task automatic do_reset();
        quiet();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_ptr = 0;
    endtask

    // TX traffic scored per cycle: grant = first valid after last winner, only when no
    // transaction is outstanding and the UART is idle; strobe exactly one cycle after grant.
    task automatic run_tx(input int ncyc, input int pval, input bit fixed);
        logic [N-1:0]   nv;
        logic [8*N-1:0] nd;
        logic [N-1:0]   exp_rdy;
        logic [7:0]     m_byte;
        bit busy, rose, prev_any, found, exp_any;
        int w, stall;
        busy = 0; rose = 0; prev_any = 0; stall = 0; m_byte = '0;
        mdl_en = 1'b1;
        for (int c = 0; c < ncyc + 100; c++) begin
            #1;
            found = 0; w = 0;
            for (int k = 1; k <= N; k++) begin
                if (!found && req_valid[(m_ptr + k) % N]) begin
                    found = 1;
                    w = (m_ptr + k) % N;
                end
            end
            exp_any = found && !busy && !uart_is_transmitting;
            exp_rdy = exp_any ? N'(1 << w) : '0;
            chk("tx_ready", req_ready, exp_rdy);
            chk("tx_strobe", uart_transmit, prev_any);
            if (busy) chk("tx_byte_hold", uart_tx_byte, m_byte);
            if (|req_valid && !exp_any) stall++;
            else stall = 0;
            if (stall > 200) begin
                n_tot++;
                $display("FAIL tx_liveness: no grant for %0d cycles, limit 200", stall);
                break;
            end
            if (exp_any) begin
                busy = 1; rose = 0; m_ptr = w;
                m_byte = req_data[w*8 +: 8];
                grants.push_back(w);
            end else if (busy) begin
                if (uart_is_transmitting) rose = 1;
                else if (rose) busy = 0;
            end
            prev_any = exp_any;
            nv = req_valid; nd = req_data;
            for (int i = 0; i < N; i++) begin
                if (exp_any && w == i) nv[i] = 1'b0;
                else if (req_valid[i]) begin
                    if (pval < 100 && $urandom_range(0, 99) < 5) nv[i] = 1'b0;
                end else if (c < ncyc && $urandom_range(0, 99) < pval) begin
                    nv[i] = 1'b1;
                    nd[i*8 +: 8] = fixed ? 8'(8'h10 + i) : 8'($urandom);
                end
            end
            if (c >= ncyc && !busy && nv == '0) break;
            tick();
            req_valid = nv; req_data = nd;
        end
        if (busy) begin
            n_tot++;
            $display("FAIL tx_drain: transaction still outstanding at end of run");
        end
        tick();
        mdl_en = 1'b0;
    endtask

    // RX traffic scored against a byte queue of the holding capacity.
    task automatic run_rx(input int ncyc);
        logic [7:0] q[$];
        bit m_ack, m_ovr, cap, ev, pop, drop;
        int m_err;
        m_ack = 0; m_ovr = 0; m_err = 0;
        for (int c = 0; c < ncyc; c++) begin
            uart_received   = ($urandom_range(0, 99) < 35);
            uart_rx_byte    = 8'($urandom);
            uart_recv_error = ($urandom_range(0, 99) < 8);
            rx_ready        = ($urandom_range(0, 99) < 40);
            stat_clr        = ($urandom_range(0, 99) < 3);
            #1;
            chk("rx_valid", rx_valid, q.size() != 0);
            if (q.size() != 0) chk("rx_data", rx_data, q[0]);
            chk("rx_overrun", rx_overrun, m_ovr);
            chk("rx_err_cnt", rx_err_cnt, m_err);
            chk("rx_ack", uart_recv_ack, m_ack);
            cap = uart_received && !uart_recv_error && !m_ack;
            ev  = uart_recv_error && !m_ack;
            pop = (q.size() != 0) && rx_ready;
            drop = 0;
            if (pop) void'(q.pop_front());
            if (cap) begin
                if (q.size() < RX_CAP) q.push_back(uart_rx_byte);
                else drop = 1;
            end
            m_ack = cap || ev;
            if (stat_clr) begin
                m_ovr = 0; m_err = 0;
            end else begin
                if (drop) m_ovr = 1;
                if (ev && m_err < 255) m_err++;
            end
            tick();
        end
        quiet();
    endtask

    typedef struct {
        logic        we;
        logic [15:0] wd;
        logic        tx;
        logic        rxb;
        logic [15:0] exp;
    } bv_t;

    initial begin
        bv_t tbl[11];
        tbl[0]  = '{1'b1, 16'd27,  1'b1, 1'b0, 16'd1302};
        tbl[1]  = '{1'b0, 16'd0,   1'b1, 1'b0, 16'd1302};
        tbl[2]  = '{1'b0, 16'd0,   1'b0, 1'b1, 16'd1302};
        tbl[3]  = '{1'b0, 16'd0,   1'b0, 1'b0, 16'd27};
        tbl[4]  = '{1'b1, 16'd0,   1'b0, 1'b0, 16'd27};
        tbl[5]  = '{1'b0, 16'd0,   1'b0, 1'b0, 16'd27};
        tbl[6]  = '{1'b1, 16'd100, 1'b1, 1'b0, 16'd27};
        tbl[7]  = '{1'b1, 16'd200, 1'b1, 1'b0, 16'd27};
        tbl[8]  = '{1'b0, 16'd0,   1'b0, 1'b0, 16'd200};
        tbl[9]  = '{1'b1, 16'd5,   1'b0, 1'b0, 16'd200};
        tbl[10] = '{1'b0, 16'd0,   1'b0, 1'b0, 16'd5};

        do_reset();
        #1;
        chk("rst_ready", req_ready, 0);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_overrun", rx_overrun, 0);
        chk("rst_err_cnt", rx_err_cnt, 0);
        chk("rst_transmit", uart_transmit, 0);
        chk("rst_tx_byte", uart_tx_byte, 0);
        chk("rst_ack", uart_recv_ack, 0);
        chk("rst_baud", uart_baud, DEF_BAUD);

        // UART restart delay: request must wait until busy falls
        man_tx = 1'b1; req_valid = 4'b0001; req_data[7:0] = 8'h41;
        for (int i = 0; i < 20; i++) begin
            #1;
            chk("restart_hold", req_ready, 0);
            tick();
        end
        man_tx = 1'b0;
        #1;
        chk("restart_grant", req_ready, 4'b0001);
        tick();
        req_valid = '0;
        #1;
        chk("restart_strobe", uart_transmit, 1);
        chk("restart_byte", uart_tx_byte, 8'h41);
        tick();
        chk("restart_strobe_end", uart_transmit, 0);
        man_tx = 1'b1;
        tick();
        man_tx = 1'b0;
        chk("restart_byte_held", uart_tx_byte, 8'h41);
        tick();
        m_ptr = 0;

        // all requesters valid continuously
        grants.delete();
        run_tx(60, 100, 1'b1);
        if (grants.size() < 8) begin
            n_tot++;
            $display("FAIL rr_count: got %0d grants expected at least 8", grants.size());
        end else begin
            for (int i = 0; i < 8; i++) chk("rr_order", grants[i], (i + 1) % N);
        end
        run_tx(400, 30, 1'b0);

        for (int r = 0; r < 11; r++) begin
            cfg_baud_we = tbl[r].we; cfg_baud_wdata = tbl[r].wd;
            man_tx = tbl[r].tx; uart_is_receiving = tbl[r].rxb;
            tick();
            chk("baud_tbl", uart_baud, tbl[r].exp);
        end
        quiet();
        tick();

        // baud write during a transmit delays a pending requester by one cycle
        man_tx = 1'b1; cfg_baud_we = 1'b1; cfg_baud_wdata = 16'd27;
        tick();
        cfg_baud_we = 1'b0;
        tick(); tick(); tick();
        chk("baud_busy_hold", uart_baud, 16'd5);
        man_tx = 1'b0; req_valid = 4'b0100; req_data[23:16] = 8'h77;
        #1;
        chk("baud_apply_blocks", req_ready, 0);
        tick();
        chk("baud_applied", uart_baud, 16'd27);
        chk("baud_late_grant", req_ready, 4'b0100);
        tick();
        req_valid = '0;
        #1;
        chk("baud_late_byte", uart_tx_byte, 8'h77);
        man_tx = 1'b1;
        tick();
        man_tx = 1'b0;
        tick(); tick();

        // two bytes with no consumer
        uart_received = 1'b1; uart_rx_byte = 8'h5A;
        tick();
        uart_received = 1'b0;
        chk("rx1_ack", uart_recv_ack, 1);
        chk("rx1_data", rx_data, 8'h5A);
        chk("rx1_valid", rx_valid, 1);
        tick();
        chk("rx1_ack_end", uart_recv_ack, 0);
        uart_received = 1'b1; uart_rx_byte = 8'hA5;
        tick();
        uart_received = 1'b0;
        chk("rx2_ack", uart_recv_ack, 1);
        tick();
        chk("rx2_ack_end", uart_recv_ack, 0);
        chk("rx2_data_kept", rx_data, 8'h5A);
`ifdef UART_CTRL_RX_FIFO_EN
        chk("rx2_overrun", rx_overrun, 0);
        rx_ready = 1'b1;
        tick();
        chk("rx_fifo_second", rx_data, 8'hA5);
        chk("rx_fifo_valid", rx_valid, 1);
        tick();
        rx_ready = 1'b0;
        chk("rx_fifo_empty", rx_valid, 0);
`else
        chk("rx2_overrun", rx_overrun, 1);
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
        chk("rx_popped", rx_valid, 0);
`endif

        // 300 error events saturate the counter
        uart_recv_error = 1'b1;
        repeat (600) tick();
        uart_recv_error = 1'b0;
        tick();
        chk("err_saturate", rx_err_cnt, 255);
        stat_clr = 1'b1; uart_recv_error = 1'b1;
        tick();
        stat_clr = 1'b0; uart_recv_error = 1'b0;
        chk("stat_clr_cnt", rx_err_cnt, 0);
        chk("stat_clr_ovr", rx_overrun, 0);
        chk("stat_clr_ack", uart_recv_ack, 1);
        tick();

        do_reset();
        run_rx(1500);
        tick();

        // reset while waiting for the transmitter to finish
        cfg_baud_we = 1'b1; cfg_baud_wdata = 16'd99;
        tick();
        cfg_baud_we = 1'b0;
        tick();
        chk("pre_rst_baud", uart_baud, 16'd99);
        uart_received = 1'b1; uart_rx_byte = 8'hC3;
        tick();
        uart_received = 1'b0;
        chk("pre_rst_rx_valid", rx_valid, 1);
        req_valid = 4'b0100; req_data[23:16] = 8'h33;
        #1;
        chk("pre_rst_grant", req_ready, 4'b0100);
        tick();
        req_valid = '0;
        tick();
        man_tx = 1'b1;
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0; man_tx = 1'b0;
        chk("wd_rst_transmit", uart_transmit, 0);
        chk("wd_rst_ack", uart_recv_ack, 0);
        chk("wd_rst_rx_valid", rx_valid, 0);
        chk("wd_rst_baud", uart_baud, DEF_BAUD);
        chk("wd_rst_tx_byte", uart_tx_byte, 0);
        req_valid = 4'b0011;
        #1;
        chk("wd_rst_idle_ptr", req_ready, 4'b0010);
        tick();
        quiet();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
